// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler
// Owns the single register-file write port. After reset it zero-fills every
// register, then each cycle arbitrates between the pipeline writeback (always
// wins, never back-pressured) and a small FIFO of multi-cycle (mul/div)
// results. Writebacks are always the newer producer, so they invalidate any
// buffered result to the same register.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   wb_valid/addr/data   pipeline writeback request
//   mc_valid/addr/data   multi-cycle result; mc_ready is the FIFO accept
//   rf_we/wa/wd          registered register-file write port
//   init_busy            registered; high while the zero-fill runs
//   pend_mask            combinational; one bit per register with a live buffered write
//   starve_stall         registered; pipeline must hold wb_valid low next cycle
module rf_write_scheduler #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              init_busy,
  output logic [NREGS-1:0]  pend_mask,
  output logic              starve_stall
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]   SMAX   = SC_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]  DEPTH  = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W:0]   NREG_C = (ADDR_W + 1)'(NREGS);
  localparam logic [PTR_W-1:0]  PLAST  = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W:0]        init_cnt_q, init_cnt_d;
  logic                   init_busy_q, init_busy_d;
  logic                   mc_ready_q, mc_ready_d;
  logic                   rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]      rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0]      rf_wd_q, rf_wd_d;
  logic                   starve_stall_q, starve_stall_d;
  logic [SC_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [BUF_DEPTH-1:0]   fifo_vld_q, fifo_vld_d;
  logic [ADDR_W-1:0]      fifo_addr_q [BUF_DEPTH];
  logic [ADDR_W-1:0]      fifo_addr_d [BUF_DEPTH];
  logic [DATA_W-1:0]      fifo_data_q [BUF_DEPTH];
  logic [DATA_W-1:0]      fifo_data_d [BUF_DEPTH];
  logic                   wb_issue, mc_xfer, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PLAST) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Next-state logic: zero-fill sequencer, write arbitration, FIFO and starvation tracking.
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    init_busy_d    = init_busy_q;
    mc_ready_d     = mc_ready_q;
    rf_we_d        = 1'b0;
    rf_wa_d        = '0;
    rf_wd_d        = '0;
    starve_stall_d = 1'b0;
    starve_cnt_d   = starve_cnt_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    fifo_vld_d     = fifo_vld_q;
    fifo_addr_d    = fifo_addr_q;
    fifo_data_d    = fifo_data_q;
    wb_issue       = 1'b0;
    mc_xfer        = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q < NREG_C) begin
          rf_we_d    = 1'b1;
          rf_wa_d    = init_cnt_q[ADDR_W-1:0];
          init_cnt_d = init_cnt_q + (ADDR_W + 1)'(1);
        end else begin
          state_d     = ST_RUN;
          init_busy_d = 1'b0;
          mc_ready_d  = 1'b1;
        end
      end
      ST_RUN: begin
        wb_issue = wb_valid && (wb_addr != '0);
        mc_xfer  = mc_valid && mc_ready_q;
        pop      = !wb_issue && (count_q != '0);
        if (wb_issue) begin
          rf_we_d = 1'b1;
          rf_wa_d = wb_addr;
          rf_wd_d = wb_data;
          // Older buffered results to the same register must never land after this write.
          for (int i = 0; i < BUF_DEPTH; i++) begin
            fifo_vld_d[i] = fifo_vld_q[i] && (fifo_addr_q[i] != wb_addr);
          end
        end else if (pop) begin
          // Invalidated or address-0 heads drain without touching the register file.
          rf_we_d = fifo_vld_q[head_q] && (fifo_addr_q[head_q] != '0);
          rf_wa_d = rf_we_d ? fifo_addr_q[head_q] : '0;
          rf_wd_d = rf_we_d ? fifo_data_q[head_q] : '0;
          fifo_vld_d[head_q] = 1'b0;
          head_d = ptr_inc(head_q);
        end else begin
          rf_we_d = 1'b0;
        end
        // A result already superseded by this cycle's writeback is accepted and dropped.
        push = mc_xfer && !(wb_issue && (mc_addr == wb_addr));
        if (push) begin
          fifo_vld_d[tail_q]  = 1'b1;
          fifo_addr_d[tail_q] = mc_addr;
          fifo_data_d[tail_q] = mc_data;
          tail_d = ptr_inc(tail_q);
        end else begin
          tail_d = tail_q;
        end
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        mc_ready_d = (count_d < DEPTH);
        if (pop) begin
          starve_cnt_d = '0;
        end else if ((count_q != '0) && (starve_cnt_q != SMAX)) begin
          starve_cnt_d = starve_cnt_q + SC_W'(1);
        end else begin
          starve_cnt_d = starve_cnt_q;
        end
        // Stays high while saturated, so an ignored stall re-asserts next cycle.
        starve_stall_d = (starve_cnt_d == SMAX);
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Pending-write mask built from the live FIFO entries.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      pend_mask = pend_mask | (fifo_vld_q[i] ? (NREGS'(1) << fifo_addr_q[i]) : '0);
    end
  end

  // State and registered-output flops; reset discards all buffered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_INIT;
      init_cnt_q     <= '0;
      init_busy_q    <= 1'b1;
      mc_ready_q     <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_wa_q        <= '0;
      rf_wd_q        <= '0;
      starve_stall_q <= 1'b0;
      starve_cnt_q   <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      fifo_vld_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      init_busy_q    <= init_busy_d;
      mc_ready_q     <= mc_ready_d;
      rf_we_q        <= rf_we_d;
      rf_wa_q        <= rf_wa_d;
      rf_wd_q        <= rf_wd_d;
      starve_stall_q <= starve_stall_d;
      starve_cnt_q   <= starve_cnt_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      fifo_vld_q     <= fifo_vld_d;
      fifo_addr_q    <= fifo_addr_d;
      fifo_data_q    <= fifo_data_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_wa        = rf_wa_q;
  assign rf_wd        = rf_wd_q;
  assign init_busy    = init_busy_q;
  assign mc_ready     = mc_ready_q;
  assign starve_stall = starve_stall_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
module tb_rf_write_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, mc_valid;
  logic [4:0]  wb_addr, mc_addr;
  logic [31:0] wb_data, mc_data;
  logic        mc_ready, rf_we, init_busy, starve_stall;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pend_mask;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  rf_write_scheduler dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
    .mc_ready(mc_ready), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .init_busy(init_busy), .pend_mask(pend_mask), .starve_stall(starve_stall)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mc_valid = mv; mc_addr = ma; mc_data = md;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) tick;
    chk_cnt++;
    if ({rf_we, rf_wa, rf_wd, init_busy, mc_ready, pend_mask, starve_stall} !==
        {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h busy=%b rdy=%b pend=%h stall=%b required 0 0 0 1 0 0 0",
               rf_we, rf_wa, rf_wd, init_busy, mc_ready, pend_mask, starve_stall);
    else pass_cnt++;
  endtask

  // Releases reset and follows the zero-fill, with requests held high to show they are ignored.
  task automatic test_init_fill;
    rst = 1'b1;
    drive(1'b1, 5'd6, 32'hCAFE0006, 1'b1, 5'd8, 32'h00000008);
    for (int k = 0; k < 32; k++) begin
      tick;
      chk_cnt++;
      if ({rf_we, rf_wa, rf_wd, init_busy} !== {1'b1, 5'(k), 32'd0, 1'b1})
        $display("FAIL init_fill[%0d]: got we=%b wa=%0d wd=%h busy=%b required we=1 wa=%0d wd=0 busy=1",
                 k, rf_we, rf_wa, rf_wd, init_busy, k);
      else pass_cnt++;
    end
    tick;
    chk_cnt++;
    if ({init_busy, mc_ready, rf_we} !== 3'b010)
      $display("FAIL init_done: got busy=%b rdy=%b we=%b required busy=0 rdy=1 we=0", init_busy, mc_ready, rf_we);
    else pass_cnt++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) begin
      tick;
      chk_cnt++;
      if ({rf_we, pend_mask} !== {1'b0, 32'd0})
        $display("FAIL init_no_stale: got we=%b wa=%0d pend=%h required we=0 pend=0", rf_we, rf_wa, pend_mask);
      else pass_cnt++;
    end
  endtask

  task automatic test_wb_and_mc;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 32'h00000012);
    tick;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk_cnt++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL wbmc_wb_write: got we=%b wa=%0d wd=%h required 1 5 deadbeef", rf_we, rf_wa, rf_wd);
    else pass_cnt++;
    chk_cnt++;
    if (pend_mask !== 32'h00000080)
      $display("FAIL wbmc_pend_set: got %h required 00000080", pend_mask);
    else pass_cnt++;
    tick;
    chk_cnt++;
    if ({rf_we, rf_wa, rf_wd, pend_mask} !== {1'b1, 5'd7, 32'h00000012, 32'd0})
      $display("FAIL wbmc_mc_write: got we=%b wa=%0d wd=%h pend=%h required 1 7 00000012 0", rf_we, rf_wa, rf_wd, pend_mask);
    else pass_cnt++;
    tick;
    chk_cnt++;
    if (rf_we !== 1'b0) $display("FAIL wbmc_idle: got we=%b required 0", rf_we);
    else pass_cnt++;
  endtask

  task automatic test_starvation;
    drive(1'b1, 5'd1, 32'h00000001, 1'b1, 5'd3, 32'h00000033);
    tick;
    drive(1'b1, 5'd2, 32'h00000002, 1'b1, 5'd4, 32'h00000044);
    tick;
    chk_cnt++;
    if ({mc_ready, rf_we, rf_wa, pend_mask} !== {1'b0, 1'b1, 5'd2, 32'h00000018})
      $display("FAIL starve_full: got rdy=%b we=%b wa=%0d pend=%h required 0 1 2 00000018", mc_ready, rf_we, rf_wa, pend_mask);
    else pass_cnt++;
    drive(1'b1, 5'd5, 32'h00000005, 1'b0, 5'd0, 32'd0);
    tick;
    drive(1'b1, 5'd6, 32'h00000006, 1'b0, 5'd0, 32'd0);
    tick;
    chk_cnt++;
    if (starve_stall !== 1'b0) $display("FAIL starve_early: got stall=%b required 0", starve_stall);
    else pass_cnt++;
    drive(1'b1, 5'd8, 32'h00000008, 1'b0, 5'd0, 32'd0);
    tick;
    chk_cnt++;
    if (starve_stall !== 1'b1) $display("FAIL starve_assert: got stall=%b required 1", starve_stall);
    else pass_cnt++;
    drive(1'b1, 5'd10, 32'h0000000A, 1'b0, 5'd0, 32'd0);
    tick;
    chk_cnt++;
    if ({starve_stall, rf_we, rf_wa} !== {1'b1, 1'b1, 5'd10})
      $display("FAIL starve_reassert: got stall=%b we=%b wa=%0d required 1 1 10", starve_stall, rf_we, rf_wa);
    else pass_cnt++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick;
    chk_cnt++;
    if ({rf_we, rf_wa, rf_wd, starve_stall, mc_ready} !== {1'b1, 5'd3, 32'h00000033, 1'b0, 1'b1})
      $display("FAIL starve_drain_r3: got we=%b wa=%0d wd=%h stall=%b rdy=%b required 1 3 00000033 0 1",
               rf_we, rf_wa, rf_wd, starve_stall, mc_ready);
    else pass_cnt++;
    tick;
    chk_cnt++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd4, 32'h00000044})
      $display("FAIL starve_drain_r4: got we=%b wa=%0d wd=%h required 1 4 00000044", rf_we, rf_wa, rf_wd);
    else pass_cnt++;
    tick;
    chk_cnt++;
    if ({rf_we, pend_mask} !== {1'b0, 32'd0})
      $display("FAIL starve_empty: got we=%b pend=%h required 0 0", rf_we, pend_mask);
    else pass_cnt++;
  endtask

  task automatic test_wb_override;
    drive(1'b1, 5'd1, 32'h00000001, 1'b1, 5'd9, 32'h00000055);
    tick;
    chk_cnt++;
    if (pend_mask !== 32'h00000200) $display("FAIL override_pend_set: got %h required 00000200", pend_mask);
    else pass_cnt++;
    drive(1'b1, 5'd9, 32'h000000AA, 1'b0, 5'd0, 32'd0);
    tick;
    chk_cnt++;
    if ({rf_we, rf_wa, rf_wd, pend_mask} !== {1'b1, 5'd9, 32'h000000AA, 32'd0})
      $display("FAIL override_wb: got we=%b wa=%0d wd=%h pend=%h required 1 9 000000aa 0", rf_we, rf_wa, rf_wd, pend_mask);
    else pass_cnt++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) begin
      tick;
      chk_cnt++;
      if ({rf_we, mc_ready} !== 2'b01)
        $display("FAIL override_silent_pop: got we=%b wa=%0d wd=%h rdy=%b required we=0 rdy=1", rf_we, rf_wa, rf_wd, mc_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_addr_zero;
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h00000005);
    for (int k = 0; k < 3; k++) begin
      tick;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk_cnt++;
      if (rf_we !== 1'b0)
        $display("FAIL addr_zero[%0d]: got we=%b wa=%0d wd=%h required we=0", k, rf_we, rf_wa, rf_wd);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({mc_ready, pend_mask} !== {1'b1, 32'd0})
      $display("FAIL addr_zero_drained: got rdy=%b pend=%h required 1 0", mc_ready, pend_mask);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 5'd1, 32'h00000001, 1'b1, 5'd3, 32'h00000033);
    tick;
    drive(1'b1, 5'd2, 32'h00000002, 1'b1, 5'd4, 32'h00000044);
    tick;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3 rst = 1'b0;
    #1;
    chk_cnt++;
    if ({rf_we, rf_wa, rf_wd, init_busy, mc_ready, pend_mask, starve_stall} !==
        {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0})
      $display("FAIL midreset_outputs: got we=%b wa=%0d wd=%h busy=%b rdy=%b pend=%h stall=%b required 0 0 0 1 0 0 0",
               rf_we, rf_wa, rf_wd, init_busy, mc_ready, pend_mask, starve_stall);
    else pass_cnt++;
    repeat (2) tick;
    test_init_fill;
  endtask

  initial begin
    test_reset;
    test_init_fill;
    test_wb_and_mc;
    test_starvation;
    test_wb_override;
    test_addr_zero;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
Owns the single register-file write port. After reset it sequences a zero-fill of every register, then arbitrates each cycle between the pipeline writeback stage and a multi-cycle execution unit (mul/div). Multi-cycle results are held in a small FIFO, with ordering and hazard protection against newer writebacks. It exports a pending-write mask for the hazard unit and a starvation stall request.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NREGS, 32, number of registers zero-filled at init (2**ADDR_W)
BUF_DEPTH, 2, multi-cycle result FIFO entries
STARVE_MAX, 4, cycles a buffered result may wait before a stall is requested

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low
wb_valid  in  1  pipeline writeback request; cannot be back-pressured
wb_addr  in  ADDR_W  writeback destination
wb_data  in  DATA_W  writeback value (signed)
mc_valid  in  1  multi-cycle result valid
mc_addr  in  ADDR_W  multi-cycle destination
mc_data  in  DATA_W  multi-cycle value (signed)
mc_ready  out  1  FIFO can accept; transfer when mc_valid && mc_ready
rf_we  out  1  register-file write enable
rf_wa  out  ADDR_W  register-file write address
rf_wd  out  DATA_W  register-file write data
init_busy  out  1  zero-fill in progress; pipeline must hold
pend_mask  out  NREGS  bit i set while a buffered write to register i is pending
starve_stall  out  1  pipeline must present wb_valid=0 next cycle

Behaviour:
- Reset (rst low, asynchronous): state=INIT, init counter=0, FIFO empty, starve counter=0.
- Output reset values: rf_we=0, rf_wa=0, rf_wd=0, init_busy=1, mc_ready=0, pend_mask=0, starve_stall=0.
- Reset asserted mid-operation discards all buffered results; no partial write is issued.
- rf_we, rf_wa, rf_wd, init_busy, mc_ready and starve_stall are registered. pend_mask is combinational from FIFO contents.
- Write latency: a request sampled at edge N drives rf_* after edge N; the register file commits it at edge N+1.
- INIT state:
  - Edges k=1..NREGS after reset release: rf_we=1, rf_wa=k-1, rf_wd=0.
  - At edge NREGS+1: state=RUN, init_busy=0, mc_ready=1 (FIFO empty).
  - wb_valid and mc_valid are ignored during INIT.
- RUN state, per-cycle priority:
  1. wb_valid with wb_addr!=0 → issue wb write.
  2. Otherwise, if FIFO non-empty → issue head and pop.
  3. Otherwise rf_we=0.
- Address-0 writes are never issued. A wb write to address 0 is discarded. A FIFO head with address 0 is popped without rf_we.
- mc_ready = (FIFO count < BUF_DEPTH), evaluated after this cycle's pop/push. No push is accepted when full, even if a pop occurs in the same cycle.
- Ordering: wb is always the newer producer.
  - When a wb write is issued to address A, every FIFO entry with address A is invalidated. Invalidated entries still pop, but without rf_we.
  - An mc transfer in the same cycle as a wb write to the same address is accepted (handshake completes) but not stored.
- pend_mask: OR of one-hot decodes of the addresses of valid FIFO entries.
- Starvation:
  - Starve counter increments each RUN cycle the FIFO is non-empty and no pop occurs; it clears on any pop and saturates at STARVE_MAX.
  - When the counter reaches STARVE_MAX, starve_stall=1 for one cycle.
  - If wb_valid is nonetheless high in the following cycle, wb still wins and starve_stall re-asserts.
- FIFO pointers wrap modulo BUF_DEPTH. Count ranges 0..BUF_DEPTH.

Test Plan:
- Reset release, idle inputs → rf_we=1 for 32 consecutive cycles with rf_wa 0..31, rf_wd=0; then init_busy=0, mc_ready=1.
- RUN: wb_valid, addr 5, data 0xDEADBEEF; same cycle mc_valid, addr 7, data 0x12 → cycle+1 write r5; cycle+2 write r7. pend_mask bit7 is set for exactly one cycle.
- mc pushes r3 then r4 while wb writes every cycle (addrs 1, 2, ...) → mc_ready=0 after second push; starve_stall=1 after 4 waiting cycles. Once wb idles, r3 is written, then r4.
- FIFO holds r9=0x55; wb writes r9=0xAA → only 0xAA is written to r9; the entry pops silently; pend_mask bit9 clears.
- wb addr 0, data 0xFFFFFFFF; mc addr 0 → no rf_we asserted for either.
- Assert rst low with 2 FIFO entries pending → all outputs take reset values immediately. After release the 32-cycle zero-fill repeats, and no stale write is issued.
